// File: rtl/rms_pkg.sv
// Shared definitions for the RMS block: default parameters, width helpers
// and FSM state encodings.
package rms_pkg;

    localparam int DEF_WIDTH = 9;
    localparam int DEF_FBITS = 4;
    localparam int DEF_N     = 8;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        ROOT  = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [1:0] S_ACCUM = 2'd0;
    localparam logic [1:0] S_ROOT  = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Accumulator wide enough for N worst-case squares of -2^(WIDTH-1).
    function automatic int acc_width(input int width, input int n);
        return 2 * width - 1 + $clog2(n);
    endfunction

    function automatic int rad_width(input int width);
        return 2 * width;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/rms_norm_seq_isqrt.sv
// Iterative digit-by-digit integer square root; two radicand bits per cycle,
// RAD_W/2 cycles from start to the done pulse.
module isqrt_seq #(
    parameter int RAD_W = 18
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [RAD_W-1:0]     rad,
    output logic                 busy,
    output logic                 done,
    output logic [RAD_W/2-1:0]   root,
    output logic [RAD_W/2:0]     rem
);

    localparam int ROOT_W = RAD_W / 2;
    localparam int CNT_W  = $clog2(ROOT_W + 1);

    generate
        if ((RAD_W % 2) != 0 || RAD_W < 4) begin : g_bad_rad_w
            $error("isqrt_seq: RAD_W must be even and at least 4");
        end
    endgenerate

    logic [RAD_W-1:0]  rad_reg;
    logic [ROOT_W:0]   rem_reg;
    logic [ROOT_W-1:0] root_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              busy_reg;
    logic              done_reg;

    logic [ROOT_W+2:0] rem_sh;
    logic [ROOT_W+2:0] trial;
    logic [ROOT_W+2:0] rem_sub;
    logic              take;

    // Remainder after each step is at most 2*root, so ROOT_W+1 bits hold it.
    assign rem_sh  = {rem_reg, rad_reg[RAD_W-1 -: 2]};
    assign trial   = {1'b0, root_reg, 2'b01};
    assign take    = (rem_sh >= trial);
    assign rem_sub = rem_sh - trial;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rad_reg  <= '0;
            rem_reg  <= '0;
            root_reg <= '0;
            cnt_reg  <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                rad_reg  <= rad;
                rem_reg  <= '0;
                root_reg <= '0;
                cnt_reg  <= CNT_W'(ROOT_W);
                busy_reg <= 1'b1;
            end else if (busy_reg) begin
                rad_reg  <= {rad_reg[RAD_W-3:0], 2'b00};
                rem_reg  <= take ? rem_sub[ROOT_W:0] : rem_sh[ROOT_W:0];
                root_reg <= {root_reg[ROOT_W-2:0], take};
                cnt_reg  <= cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    busy_reg <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign root = root_reg;
    assign rem  = rem_reg;

endmodule

// File: rtl/rms_norm_seq.sv
// Streaming RMS of N signed fixed-point samples: accumulate squares, divide
// by N with a shift, then take the root with the sequential isqrt unit.
module rms_norm_seq
    import rms_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FBITS = DEF_FBITS,
    parameter int N     = DEF_N
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_rms,
    output logic [2*WIDTH-1:0]      out_mean_sq
);

    localparam int LOG2N  = $clog2(N);
    localparam int ACC_W  = acc_width(WIDTH, N);
    localparam int RAD_W  = rad_width(WIDTH);
    localparam int MEAN_W = 2 * WIDTH - 1;

    generate
        if (!is_pow2(N)) begin : g_bad_n
            $error("rms_norm_seq: N must be a power of two and at least 2");
        end
        if (FBITS < 0 || FBITS >= WIDTH) begin : g_bad_fbits
            $error("rms_norm_seq: FBITS must lie in [0, WIDTH)");
        end
    endgenerate

    logic [1:0]        state_reg,     state_next;
    logic [LOG2N-1:0]  count_reg,     count_next;
    logic [ACC_W-1:0]  acc_reg,       acc_next;
    logic [MEAN_W-1:0] mean_reg,      mean_next;
    logic              out_valid_reg, out_valid_next;
    logic [WIDTH-1:0]  out_rms_reg,   out_rms_next;
    logic [MEAN_W-1:0] out_mean_reg,  out_mean_next;

    logic signed [2*WIDTH-1:0] sq_s;
    logic [ACC_W-1:0]          sum;
    logic [MEAN_W-1:0]         mean;
    logic [LOG2N-1:0]          sum_lsb_unused;
    logic                      in_fire;
    logic                      last_beat;
    logic                      root_done;
    logic [WIDTH-1:0]          root_val;
    logic                      root_busy_unused;
    logic [WIDTH:0]            root_rem_unused;

    // A square is never negative, so the signed product reinterprets losslessly.
    assign sq_s      = in_data * in_data;
    assign sum       = acc_reg + ACC_W'($unsigned(sq_s));
    assign {mean, sum_lsb_unused} = sum;
    assign in_ready  = (state_reg == S_ACCUM);
    assign in_fire   = in_valid && in_ready;
    assign last_beat = in_fire && (count_reg == LOG2N'(N - 1));

    isqrt_seq #(
        .RAD_W(RAD_W)
    ) u_isqrt (
        .clk   (clk),
        .rst_n (rst_n),
        .start (last_beat),
        .rad   ({1'b0, mean}),
        .busy  (root_busy_unused),
        .done  (root_done),
        .root  (root_val),
        .rem   (root_rem_unused)
    );

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        acc_next       = acc_reg;
        mean_next      = mean_reg;
        out_valid_next = out_valid_reg;
        out_rms_next   = out_rms_reg;
        out_mean_next  = out_mean_reg;
        case (state_reg)
            S_ACCUM: begin
                if (in_fire) begin
                    acc_next   = sum;
                    count_next = count_reg + LOG2N'(1);
                    if (last_beat) begin
                        mean_next  = mean;
                        count_next = '0;
                        state_next = S_ROOT;
                    end
                end
            end
            S_ROOT: begin
                if (root_done) begin
                    out_rms_next   = root_val;
                    out_mean_next  = mean_reg;
                    out_valid_next = 1'b1;
                    state_next     = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    acc_next       = '0;
                    state_next     = S_ACCUM;
                end
            end
            default: state_next = S_ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= S_ACCUM;
            count_reg     <= '0;
            acc_reg       <= '0;
            mean_reg      <= '0;
            out_valid_reg <= 1'b0;
            out_rms_reg   <= '0;
            out_mean_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            acc_reg       <= acc_next;
            mean_reg      <= mean_next;
            out_valid_reg <= out_valid_next;
            out_rms_reg   <= out_rms_next;
            out_mean_reg  <= out_mean_next;
        end
    end

    assign out_valid   = out_valid_reg;
    assign out_rms     = out_rms_reg;
    assign out_mean_sq = {1'b0, out_mean_reg};

endmodule

// File: tb/tb_rms_norm_seq.sv
// Scoreboard bench for rms_norm_seq at WIDTH=9, FBITS=4, N=8.
module tb_rms_norm_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [8:0]  in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [8:0]  out_rms;
    logic [17:0] out_mean_sq;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int rms;
        int mean;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    rms_norm_seq #(.WIDTH(9), .FBITS(4), .N(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rms     (out_rms),
        .out_mean_sq (out_mean_sq)
    );

    function automatic exp_t model(input int vals[8]);
        exp_t e;
        int   s = 0;
        for (int i = 0; i < 8; i++) s += vals[i] * vals[i];
        e.mean = s / 8;
        e.rms  = 0;
        while ((e.rms + 1) * (e.rms + 1) <= e.mean) e.rms++;
        return e;
    endfunction

    task automatic send_vec(input int vals[8], input bit gap, input bit push);
        bit rdy;
        int guard;
        for (int i = 0; i < 8; i++) begin
            if (gap) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = 9'(vals[i]);
            guard = 0;
            do begin
                rdy = in_ready;
                @(posedge clk); #1;
                guard++;
            end while (!rdy && guard < 100);
            if (!rdy) begin
                n_checks++; n_fail++;
                $display("FAIL send_timeout: in_ready stayed %0b, required 1", in_ready);
            end
        end
        in_valid = 1'b0;
        if (push) sb.push_back(model(vals));
    endtask

    // Waits for out_valid (bounded), captures outputs, then lets one edge pass.
    task automatic collect(output int cyc, output logic v, output logic [8:0] r,
                           output logic [17:0] m);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        v = out_valid;
        r = out_rms;
        m = out_mean_sq;
        $display("result: cyc=%0d valid=%0b rms=%0d mean_sq=%0d", cyc, v, r, m);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_checks++; if (out_rms !== 9'd0) begin n_fail++; $display("FAIL reset_out_rms: got %0d want 0", out_rms); end
        n_checks++; if (out_mean_sq !== 18'd0) begin n_fail++; $display("FAIL reset_out_mean_sq: got %0d want 0", out_mean_sq); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unit();
        int vals[8] = '{16, 16, 16, 16, 16, 16, 16, 16};
        int cyc; logic v; logic [8:0] r; logic [17:0] m; exp_t e;
        send_vec(vals, 1'b0, 1'b1);
        collect(cyc, v, r, m);
        e = sb.pop_front();
        n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL unit_latency: got %0d cycles want 10", cyc); end
        n_checks++; if (r !== 9'd16 || r !== 9'(e.rms)) begin n_fail++; $display("FAIL unit_rms: got %0d want %0d", r, e.rms); end
        n_checks++; if (m !== 18'd256 || m !== 18'(e.mean)) begin n_fail++; $display("FAIL unit_mean_sq: got %0d want %0d", m, e.mean); end
    endtask

    task automatic test_min();
        int vals[8] = '{-256, -256, -256, -256, -256, -256, -256, -256};
        int cyc; logic v; logic [8:0] r; logic [17:0] m; exp_t e;
        send_vec(vals, 1'b0, 1'b1);
        collect(cyc, v, r, m);
        e = sb.pop_front();
        n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL min_valid: got %0b want 1", v); end
        n_checks++; if (r !== 9'h100 || r !== 9'(e.rms)) begin n_fail++; $display("FAIL min_rms: got %0d want %0d", r, e.rms); end
        n_checks++; if (m !== 18'd65536 || m !== 18'(e.mean)) begin n_fail++; $display("FAIL min_mean_sq: got %0d want %0d", m, e.mean); end
    endtask

    task automatic test_sparse_and_zero();
        int v1[8] = '{32, 0, 0, 0, 0, 0, 0, 0};
        int v0[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
        int cyc; logic v; logic [8:0] r; logic [17:0] m; exp_t e;
        send_vec(v1, 1'b0, 1'b1);
        collect(cyc, v, r, m);
        e = sb.pop_front();
        n_checks++; if (r !== 9'd11 || r !== 9'(e.rms)) begin n_fail++; $display("FAIL sparse_rms: got %0d want %0d", r, e.rms); end
        n_checks++; if (m !== 18'd128 || m !== 18'(e.mean)) begin n_fail++; $display("FAIL sparse_mean_sq: got %0d want %0d", m, e.mean); end
        send_vec(v0, 1'b0, 1'b1);
        collect(cyc, v, r, m);
        e = sb.pop_front();
        n_checks++; if (v !== 1'b1) begin n_fail++; $display("FAIL zero_valid: got %0b want 1", v); end
        n_checks++; if (r !== 9'(e.rms)) begin n_fail++; $display("FAIL zero_rms: got %0d want %0d", r, e.rms); end
        n_checks++; if (m !== 18'(e.mean)) begin n_fail++; $display("FAIL zero_mean_sq: got %0d want %0d", m, e.mean); end
    endtask

    task automatic test_backpressure();
        int vals[8] = '{-100, 37, 255, -3, 0, 90, -256, 12};
        int cyc; logic v; logic [8:0] r; logic [17:0] m; exp_t e;
        out_ready = 1'b0;
        send_vec(vals, 1'b0, 1'b1);
        collect(cyc, v, r, m);
        e = sb.pop_front();
        n_checks++; if (r !== 9'(e.rms)) begin n_fail++; $display("FAIL bp_rms: got %0d want %0d", r, e.rms); end
        n_checks++; if (m !== 18'(e.mean)) begin n_fail++; $display("FAIL bp_mean_sq: got %0d want %0d", m, e.mean); end
        in_valid = 1'b1;
        in_data  = 9'd100;
        for (int k = 0; k < 5; k++) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold_valid[%0d]: got %0b want 1", k, out_valid); end
            n_checks++; if (out_rms !== r) begin n_fail++; $display("FAIL bp_hold_rms[%0d]: got %0d want %0d", k, out_rms, r); end
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %0b want 0", k, in_ready); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %0b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_gapped();
        int vals[8] = '{1, 2, 3, 4, 5, 6, 7, 8};
        int cyc; logic v; logic [8:0] r; logic [17:0] m; exp_t e;
        send_vec(vals, 1'b1, 1'b1);
        collect(cyc, v, r, m);
        e = sb.pop_front();
        n_checks++; if (r !== 9'd5 || r !== 9'(e.rms)) begin n_fail++; $display("FAIL gapped_rms: got %0d want %0d", r, e.rms); end
        n_checks++; if (m !== 18'd25 || m !== 18'(e.mean)) begin n_fail++; $display("FAIL gapped_mean_sq: got %0d want %0d", m, e.mean); end
    endtask

    task automatic test_reset_mid_op();
        int junk[8] = '{200, -200, 150, -150, 99, 1, -7, 255};
        int unit[8] = '{16, 16, 16, 16, 16, 16, 16, 16};
        int cyc; logic v; logic [8:0] r; logic [17:0] m; exp_t e;
        bit seen;
        send_vec(junk, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_root_valid: got %0b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_root_in_ready: got %0b want 1", in_ready); end
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (out_valid === 1'b1) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rst_root_partial: got out_valid=1 want none"); end
        // Abort a vector part way through accumulation as well.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 9'd255;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_vec(unit, 1'b0, 1'b1);
        collect(cyc, v, r, m);
        e = sb.pop_front();
        n_checks++; if (cyc !== 10) begin n_fail++; $display("FAIL rst_after_latency: got %0d want 10", cyc); end
        n_checks++; if (r !== 9'd16 || r !== 9'(e.rms)) begin n_fail++; $display("FAIL rst_after_rms: got %0d want %0d", r, e.rms); end
        n_checks++; if (m !== 18'(e.mean)) begin n_fail++; $display("FAIL rst_after_mean_sq: got %0d want %0d", m, e.mean); end
    endtask

    task automatic test_back_to_back();
        int vals[8];
        int cyc; logic v; logic [8:0] r; logic [17:0] m; exp_t e;
        for (int t = 0; t < 6; t++) begin
            for (int i = 0; i < 8; i++) vals[i] = int'($urandom_range(0, 511)) - 256;
            send_vec(vals, 1'b0, 1'b1);
            collect(cyc, v, r, m);
            e = sb.pop_front();
            n_checks++; if (r !== 9'(e.rms)) begin n_fail++; $display("FAIL b2b_rms[%0d]: got %0d want %0d", t, r, e.rms); end
            n_checks++; if (m !== 18'(e.mean)) begin n_fail++; $display("FAIL b2b_mean_sq[%0d]: got %0d want %0d", t, m, e.mean); end
        end
    endtask

    initial begin
        test_reset();
        test_unit();
        test_min();
        test_sparse_and_zero();
        test_backpressure();
        test_gapped();
        test_reset_mid_op();
        test_back_to_back();
        if (sb.size() != 0) begin
            n_checks++; n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rms_norm_seq.md
Name: rms_norm_seq

Overview:
- Sequential, parametrised RMS unit: accepts N signed fixed-point samples over a valid/ready stream and accumulates their squares.
- Divides the sum by N, then takes the square root with an iterative digit-by-digit unit.
- Presents the RMS on a valid/ready output.
- Successor to the fixed 8-input combinational sum-of-squares: it adds generic N/WIDTH/FBITS, a real root stage and flow control. It sits ahead of the normalisation scaler.

Parameters:
- WIDTH, 9, sample width, two's complement, Q(WIDTH-FBITS).FBITS.
- FBITS, 4, fractional bits of samples and of result.
- N, 8, samples per vector; power of two, >= 2.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  sample present.
- in_ready  out  1  block accepts sample this cycle.
- in_data  in  WIDTH  signed sample.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_rms  out  WIDTH  unsigned RMS, FBITS fractional bits.
- out_mean_sq  out  2*WIDTH  unsigned mean of squares, 2*FBITS fractional bits.

Behaviour:
- Clock and reset: one clock, clk. rst_n synchronous, active-low; sampled on the rising edge only.
- Reset values: state=ACCUM, count=0, acc=0, in_ready=1, out_valid=0, out_rms=0, out_mean_sq=0.
- Reset mid-operation: any state, any cycle, aborts the vector with no partial output.
- States:
  - ACCUM: in_ready=1. A beat is accepted when in_valid&in_ready. On accept, acc += in_data*in_data (signed multiply, unsigned result) and count++. On the Nth accepted beat: mean = (acc+sq) >> log2(N), truncating; load the root unit; count=0; go to ROOT.
  - ROOT: in_ready=0. The root unit retires 2 radicand bits per cycle, WIDTH iterations on the 2*WIDTH-bit mean. After the final iteration, register out_rms=floor(sqrt(mean)) and out_mean_sq=mean, set out_valid=1 and go to DONE.
  - DONE: in_ready=0. Outputs are held stable while out_valid&!out_ready. On out_valid&out_ready: out_valid=0, acc=0, go to ACCUM. The next sample is accepted no earlier than the following cycle; there is no same-cycle overlap.
- Latency: out_valid rises exactly WIDTH+1 cycles after the edge that accepts the Nth sample.
- Throughput: one vector per N+WIDTH+2 cycles minimum.
- Widths:
  - Square <= 2^(2*WIDTH-2), reached at in_data = -2^(WIDTH-1).
  - acc is 2*WIDTH-1+log2(N) bits and never overflows.
  - Mean fits in 2*WIDTH-1 bits.
  - Root <= 2^(WIDTH-1), so it always fits unsigned WIDTH bits; no saturation is needed.
- Fixed point: the squared domain has 2*FBITS fractional bits; its root has FBITS, so no post-shift is applied.
- Remainder is computed internally and not exported.
- in_valid while in_ready=0 is ignored; the upstream holds the data.
- out_ready is don't-care while out_valid=0.
- Parameter check: elaboration fails if N is not a power of two or N<2.

Decomposition:
- Package rms_pkg:
  - localparams LOG2N = $clog2(N), ACC_W = 2*WIDTH-1+LOG2N, RAD_W = 2*WIDTH.
  - State typedef enum {ACCUM, ROOT, DONE}.
- Sub-module isqrt_seq, parameter RAD_W:
  - Iterative digit-by-digit root over RAD_W/2 cycles.
  - Interface: start, rad, busy, done pulse, root, rem; synchronous active-low rst_n.
  - Reusable elsewhere.
- rms_norm_seq owns the stream handshakes, accumulator, counter and FSM.

Test Plan (WIDTH=9, FBITS=4, N=8):
- Eight samples of 16 (1.0), out_ready=1 -> out_mean_sq=256, out_rms=16; out_valid exactly 10 cycles after the 8th accept.
- Eight samples of -256 (min) -> out_mean_sq=65536, out_rms=256 (0x100); no overflow.
- Samples {32,0,0,0,0,0,0,0} -> out_mean_sq=128, out_rms=11 (floor sqrt); all zeros -> out_rms=0, out_mean_sq=0.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_rms and out_valid held constant, in_ready=0, extra in_valid beats ignored; then out_ready=1 -> out_valid=0 next cycle, in_ready=1.
- Gapped input: in_valid toggled 1/0 across 16 cycles with values 1..8 -> sum 204*... check: squares of 1..8 sum 204, mean 25, out_rms=5.
- Reset mid-ROOT: rst_n=0 for one cycle during iteration 4 -> out_valid=0, in_ready=1 after release; next 8 samples of 16 give out_rms=16, proving acc and count were cleared.
